// File: rtl/sram_responder.sv
// sram_responder: SRAM-side responder for the core's single-port memory bus.
// Serves combinational reads and clocked core stores, and contains a
// byte-stream program loader that fills memory after reset while holding the
// core in reset, then releases it.
// Optional feature macro: SRAM_WPROT_EN (write-protect the loaded image).
module sram_responder #(
  parameter int          ADDR_W   = 8,
  parameter logic [15:0] OOR_DATA = 16'hF000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       sram_addr,
  input  logic              sram_we_n,
  input  logic [15:0]       sram_q,
  output logic [15:0]       sram_d,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              core_reset_n,
  output logic [ADDR_W:0]   prog_words,
  output logic              wp_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  ld_ptr;
  logic [7:0]         hold;
  logic [15:0]        mem [DEPTH];

  logic               in_range;
  logic [ADDR_W-1:0]  core_idx;
  logic               core_wr;
  logic               wp_hit;
  logic               core_we;
  logic               ld_acc;
  logic               ld_we;
  logic [15:0]        ld_wdata;

  assign in_range = (sram_addr[15:ADDR_W] == '0);
  assign core_idx = sram_addr[ADDR_W-1:0];
  // Core store attempt: only meaningful once the core is running.
  assign core_wr  = (state == RUN) && !sram_we_n && in_range;

`ifdef SRAM_WPROT_EN
  // Words below prog_words hold the loaded image and are read-only to the core.
  assign wp_hit = ({1'b0, core_idx} < prog_words);
`else
  assign wp_hit = 1'b0;
`endif

  assign core_we  = core_wr && !wp_hit;
  // Loader accepts bytes only in the load states; RUN ignores it entirely.
  assign ld_acc   = ld_valid && (state != RUN);
  assign ld_we    = ld_acc && ((state == LOAD_LO) || ld_last);
  // A lone trailing high byte is padded with a zero low byte.
  assign ld_wdata = (state == LOAD_LO) ? {hold, ld_byte} : {ld_byte, 8'h00};

  // Combinational read; out-of-range addresses return a safe opcode.
  assign sram_d = in_range ? mem[core_idx] : OOR_DATA;

  // Memory array: loader and core writes are mutually exclusive by state.
  // Not reset; contents survive a reset so a reload can be partial.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (ld_we)        mem[ld_ptr]   <= ld_wdata;
      else if (core_we) mem[core_idx] <= sram_q;
    end
  end

  // Loader FSM with registered handshake/reset outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= LOAD_HI;
      ld_ptr       <= '0;
      prog_words   <= '0;
      hold         <= 8'h00;
      ld_ready     <= 1'b1;
      core_reset_n <= 1'b0;
    end else begin
      case (state)
        LOAD_HI: if (ld_acc) begin
          hold <= ld_byte;
          if (ld_last) begin
            prog_words   <= prog_words + 1'b1;
            state        <= RUN;
            ld_ready     <= 1'b0;
            core_reset_n <= 1'b1;
          end else begin
            state <= LOAD_LO;
          end
        end
        LOAD_LO: if (ld_acc) begin
          ld_ptr     <= ld_ptr + 1'b1;
          prog_words <= prog_words + 1'b1;
          // Stop on the image end or when the last word has been filled.
          if (ld_last || (ld_ptr == '1)) begin
            state        <= RUN;
            ld_ready     <= 1'b0;
            core_reset_n <= 1'b1;
          end else begin
            state <= LOAD_HI;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_WPROT_EN
  logic wp_err_q;
  // Sticky flag for a core store that hit the protected image.
  always_ff @(posedge clk) begin
    if (!reset)                 wp_err_q <= 1'b0;
    else if (core_wr && wp_hit) wp_err_q <= 1'b1;
  end
  assign wp_err = wp_err_q;
`else
  assign wp_err = 1'b0;
`endif

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the processor's single-port SRAM bus: serves combinational instruction/data reads and clocked stores issued by the control FSM. Also contains a byte-stream program loader that fills memory after reset while holding the core in reset, then releases it. Sits between the top level and the control FSM's `sram_addr`/`sram_we_n`/`sram_q`/`sram_d` signals.

## Interface
- `ADDR_W`, 8: implemented word-address bits; depth = 2**ADDR_W 16-bit words.
- `OOR_DATA`, 16'hF000: read value for out-of-range addresses (decodes as jump-to-0).
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `sram_addr`  in  16  word address from core.
- `sram_we_n`  in  1  active-low write strobe from core.
- `sram_q`  in  16  write data from core.
- `sram_d`  out  16  read data to core, combinational.
- `ld_valid`  in  1  loader byte valid.
- `ld_byte`  in  8  loader byte, high byte of each word first.
- `ld_last`  in  1  marks final byte of image, qualified by `ld_valid`.
- `ld_ready`  out  1  loader can accept a byte this cycle.
- `core_reset_n`  out  1  active-low reset to the control FSM.
- `prog_words`  out  ADDR_W+1  number of words written by the loader.
- `wp_err`  out  1  sticky write-protect violation flag.

## Operation
- States: `LOAD_HI`, `LOAD_LO`, `RUN`. Reset (`reset`=0 at an edge) -> `LOAD_HI`, `ld_ptr`=0, `prog_words`=0, `wp_err`=0, holding register=0. Memory contents are not cleared.
- Outputs by state: `ld_ready`=1 in `LOAD_HI`/`LOAD_LO`, 0 in `RUN`; `core_reset_n`=0 except in `RUN`.
- Byte accepted when `ld_valid & ld_ready`.
- `LOAD_HI`: accepted byte -> holding register; -> `LOAD_LO`. If `ld_last` set: write `{byte, 8'h00}` to `mem[ld_ptr]`, increment `prog_words`, -> `RUN`.
- `LOAD_LO`: accepted byte -> write `{hold, byte}` to `mem[ld_ptr]`; increment `ld_ptr` and `prog_words`. -> `RUN` if `ld_last` set or the write was to address 2**ADDR_W-1 (memory full); else -> `LOAD_HI`.
- `RUN`: terminal until reset; loader inputs ignored.
- Read: `sram_d = mem[sram_addr[ADDR_W-1:0]]` when `sram_addr[15:ADDR_W]`==0, else `OOR_DATA`. Valid in all states.
- Core write: in `RUN`, `sram_we_n`=0 at an edge with in-range address writes `sram_q`. Out-of-range writes are dropped silently. Core writes in load states are ignored.
- Read during write to same address returns old data in that cycle; new data from the next cycle.

## Timing
- Read latency 0 (combinational); write takes effect at the clock edge.
- Loader: one byte per cycle maximum; two accepted bytes per word; word visible on `sram_d` the cycle after the low byte is accepted.
- `core_reset_n` rises in the first cycle in `RUN` (registered), one cycle after the final byte is accepted.
- Reset mid-load: restart at `LOAD_HI`, pointer 0. A pending high byte is discarded. Words already written remain.

## Configuration
- `SRAM_WPROT_EN` defined: in `RUN`, a core write to an in-range address < `prog_words` is dropped and sets `wp_err` at that edge. `wp_err` is sticky until reset.
- Undefined: all in-range core writes are accepted; `wp_err` is tied 0.

## Test plan
- Load bytes 12,34,56,78 with `ld_last` on 78 -> mem[0]=16'h1234, mem[1]=16'h5678, `prog_words`=2, `core_reset_n`=1 the cycle after 78 is accepted.
- Odd image 0xAB with `ld_last` -> mem[0]=16'hAB00, `prog_words`=1, state `RUN`.
- In `RUN`, set `sram_addr`=16'h0100 and `sram_we_n`=0 (ADDR_W=8) -> no write; `sram_d`=16'hF000. Set `sram_addr`=5 -> `sram_d`=mem[5] in the same cycle.
- Stream 2*256 bytes with no `ld_last` -> final word at 255, `prog_words`=256, `ld_ready`=0, `RUN` entered.
- With `SRAM_WPROT_EN` and `prog_words`=2: write 16'hBEEF to addr 1 -> mem[1] unchanged, `wp_err`=1. Write to addr 2 -> accepted.
- Assert `reset` after 3 loader bytes -> `LOAD_HI`, `prog_words`=0, `core_reset_n`=0, mem[0] retains its previously written value.
